uart_ctrl: RTL and testbench
============================

# uart_ctrl

Parametrised, runtime-configurable UART controller that supersedes the fixed 8N1 UART top level. It integrates a programmable baud-tick generator, TX and RX serialisers, and show-ahead TX/RX FIFOs. It adds configurable data width, parity, stop bits, sticky error reporting (frame, parity, overrun) and glitch rejection on the start bit. It sits between the image-pipeline host logic and the board serial pins.

## Interface
Parameters:
- DATA_BITS, 8: data bits per frame, 5..9.
- FIFO_DEPTH, 16: entries per FIFO, power of two, ≥2.
- DIV_WIDTH, 16: width of the baud divisor.
- OVERSAMPLE, 16: ticks per bit, even, ≥4.

Ports:
- clk  in  1  system clock.
- rstN  in  1  reset. Asynchronous assert, active-low.
- cfg_div  in  DIV_WIDTH  tick period minus 1; a tick occurs every cfg_div+1 cycles.
- cfg_parity_en  in  1  parity bit present.
- cfg_parity_odd  in  1  odd parity when 1, even parity when 0.
- cfg_two_stop  in  1  TX sends 2 stop bits.
- rx  in  1  serial input, asynchronous to clk.
- tx  out  1  serial output.
- rx_rd  in  1  pop the RX FIFO.
- rx_rd_data  out  DATA_BITS  RX FIFO head, show-ahead.
- rx_valid  out  1  RX head valid (equals !rx_empty).
- rx_empty  out  1  RX FIFO empty.
- rx_count  out  $clog2(FIFO_DEPTH)+1  RX occupancy.
- tx_wr  in  1  push tx_wr_data.
- tx_wr_data  in  DATA_BITS  word to send.
- tx_full  out  1  TX FIFO full.
- tx_busy  out  1  TX FSM not IDLE, or TX FIFO non-empty.
- err  out  3  sticky flags {overrun, parity, frame}.
- err_clr  in  1  clears all err bits.

## Operation
- **Tick generator:** the counter counts 0..cfg_div, then wraps to 0 and pulses tick for one cycle.
  - cfg_div=0 pulses tick every cycle.
  - A cfg_div change takes effect at the next wrap.
- **Config latch:** each FSM latches the cfg_* inputs at frame start. A mid-frame change never corrupts the frame in progress.
- **Bit order:** LSB first.
- **Parity:** the parity bit equals XOR of the data bits, inverted when cfg_parity_odd=1.
- **TX FSM states:** IDLE → START → DATA → PARITY (skipped if parity disabled) → STOP → IDLE.
  - Each bit lasts OVERSAMPLE ticks.
  - STOP lasts 1 or 2 bits, per cfg_two_stop.
  - In IDLE with the FIFO non-empty, the FSM pops the head into the shift register in the same cycle and enters START.
  - Back-to-back frames have no idle gap.
- **RX synchroniser:** rx passes through a 2-flop synchroniser. The FSM sees only the synchronised signal.
- **RX FSM states:** IDLE → START → DATA → PARITY → STOP → IDLE.
  - IDLE: a falling level (synchronised rx = 0) enters START and clears the tick counter.
  - START: at OVERSAMPLE/2 ticks, rx is resampled. If it is 1, the start is a glitch: return to IDLE with no push and no error.
  - DATA and PARITY: each bit is sampled after a further OVERSAMPLE ticks, i.e. at mid-bit.
  - STOP: exactly one stop bit is checked, regardless of cfg_two_stop.
- **RX frame completion:** at the mid-stop sample:
  - stop sample = 0 sets err[0] (frame).
  - parity mismatch sets err[1] (parity).
  - The data is pushed even if err[0] or err[1] was set.
  - If the RX FIFO is full, the word is dropped and err[2] (overrun) is set.
  - The FSM then returns to IDLE and can detect the next start immediately.
- **FIFOs (both):**
  - A write when full is ignored. A read when empty is ignored.
  - Simultaneous read and write when full: both take effect and occupancy is unchanged.
  - Simultaneous read and write when empty: only the write takes effect.
  - Pointers wrap modulo FIFO_DEPTH.
- **Error flags:** bits are sticky until err_clr. If err_clr coincides with a new error event, the set wins.
- **Reset:** clears FIFOs, FSMs, counters, synchroniser (to 1) and err.

## Timing
- **Reset values:**
  - tx=1, rx_empty=1, rx_valid=0, rx_count=0, tx_full=0, tx_busy=0, err=0.
  - rx_rd_data=0, and it is don't-care while empty.
- **TX latency:** with tx_wr at cycle N, TX idle and FIFO empty:
  - tx_busy=1 at N+1.
  - The FSM pops at N+1 and tx is driven low (registered) at N+2.
- **Frame length:** (1 + DATA_BITS + cfg_parity_en + 1 + cfg_two_stop) × OVERSAMPLE × (cfg_div+1) cycles.
- **RX latency:** rx_valid rises the cycle after the mid-stop-bit sample. With ideal input, that is 2 synchroniser cycles plus (DATA_BITS + cfg_parity_en + 1.5) bit times after the falling edge of the start bit.
- **Full flag:** tx_full asserts the cycle after the write that fills the FIFO.
- **rx_rd:** rx_rd_data updates the cycle after rx_rd.
- **Reset mid-frame:** tx returns to 1 asynchronously. The partial RX frame is discarded and no flag is set.

## Test plan
- **Loopback 8N1:** tx→rx, cfg_div=0, OVERSAMPLE=16, write 0xA5.
  - First tx low at N+2.
  - Frame is 160 cycles.
  - rx_rd_data=0xA5, err=0.
- **Odd parity burst:** cfg_parity_en=1, cfg_parity_odd=1, cfg_two_stop=1, cfg_div=3. Write 0x00, 0xFF, 0x3C back-to-back.
  - Parity bits are 1, 1, 1 (each word has even ones count).
  - No idle gap between frames.
  - All three words are received in order.
- **Error injection:** drive rx manually.
  - Wrong parity on 0x12 → err=3'b010, 0x12 pushed.
  - Stop bit 0 → err[0] also set.
  - err_clr → err=0.
- **Overrun:** FIFO_DEPTH=4, send 5 frames without rx_rd.
  - rx_count=4.
  - err[2]=1.
  - FIFO holds the first 4 words.
- **Glitch rejection:** rx low for OVERSAMPLE/4 ticks.
  - No push, err=0.
  - A following valid frame 0x5A is received correctly.
- **Reset mid-frame:** assert rstN during a TX data bit.
  - tx=1 immediately, tx_busy=0, FIFOs empty.
  - The next write transmits normally.

Source files
------------

// File: rtl/uart_ctrl.sv
// uart_ctrl: runtime-configurable UART with baud tick generator, TX/RX serialisers and show-ahead FIFOs
module uart_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic                     wr,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          do_wr, do_rd;
    assign do_rd   = rd && count != '0;
    assign do_wr   = wr && (count != CW'(DEPTH) || do_rd);
    assign rd_data = count == '0 ? '0 : mem[rptr];
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rstN)
        if (!rstN) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(do_wr);
            rptr  <= rptr + AW'(do_rd);
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    // storage needs no reset; the head is masked while empty
    always_ff @(posedge clk)
        if (do_wr) mem[wptr] <= wr_data;
endmodule

module uart_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic [DIV_WIDTH-1:0]          cfg_div,
    input  logic                          cfg_parity_en,
    input  logic                          cfg_parity_odd,
    input  logic                          cfg_two_stop,
    input  logic                          rx,
    output logic                          tx,
    input  logic                          rx_rd,
    output logic [DATA_BITS-1:0]          rx_rd_data,
    output logic                          rx_valid,
    output logic                          rx_empty,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    input  logic                          tx_wr,
    input  logic [DATA_BITS-1:0]          tx_wr_data,
    output logic                          tx_full,
    output logic                          tx_busy,
    output logic [2:0]                    err,
    input  logic                          err_clr
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [SW-1:0] LAST     = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] HALF     = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DIV_WIDTH-1:0] div_cnt, div_q;
    logic                 tick;
    assign tick = div_cnt == div_q;
    // free-running tick counter; a new divisor is picked up at each wrap
    always_ff @(posedge clk or negedge rstN)
        if (!rstN) begin
            div_cnt <= '0;
            div_q   <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            div_q   <= cfg_div;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end

    state_t               tx_state, tx_state_n;
    logic [SW-1:0]        tx_cnt, tx_cnt_n;
    logic [BW-1:0]        tx_bit, tx_bit_n;
    logic [DATA_BITS-1:0] tx_sh, tx_sh_n, tx_head;
    logic                 tx_pen, tx_pen_n, tx_par, tx_par_n, tx_two, tx_two_n, tx_n, tx_pop, tx_end;
    logic [CW-1:0]        tx_count;

    uart_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rstN(rstN), .wr(tx_wr), .wr_data(tx_wr_data),
        .rd(tx_pop), .rd_data(tx_head), .count(tx_count)
    );

    assign tx_end  = tick && tx_cnt == LAST;
    assign tx_busy = tx_state != IDLE || tx_count != '0;
    assign tx_full = tx_count == CW'(FIFO_DEPTH);

    // TX next state; a finishing stop bit reloads straight into START when data waits
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tick ? (tx_end ? '0 : tx_cnt + 1'b1) : tx_cnt;
        tx_bit_n   = tx_bit;
        tx_sh_n    = tx_sh;
        tx_pen_n   = tx_pen;
        tx_par_n   = tx_par;
        tx_two_n   = tx_two;
        tx_pop     = 1'b0;
        case (tx_state)
            START:  if (tx_end) begin
                        tx_state_n = DATA;
                        tx_bit_n   = '0;
                    end
            DATA:   if (tx_end) begin
                        tx_sh_n  = tx_sh >> 1;
                        tx_bit_n = tx_bit + 1'b1;
                        if (tx_bit == LAST_BIT) begin
                            tx_state_n = tx_pen ? PARITY : STOP;
                            tx_bit_n   = '0;
                        end
                    end
            PARITY: if (tx_end) tx_state_n = STOP;
            STOP:   if (tx_end) begin
                        tx_bit_n = tx_bit + 1'b1;
                        if (!tx_two || tx_bit != '0) tx_state_n = IDLE;
                    end
            default: ;
        endcase
        if (tx_state_n == IDLE && tx_count != '0) begin
            tx_pop     = 1'b1;
            tx_state_n = START;
            tx_cnt_n   = '0;
            tx_sh_n    = tx_head;
            tx_pen_n   = cfg_parity_en;
            tx_par_n   = ^tx_head ^ cfg_parity_odd;
            tx_two_n   = cfg_two_stop;
        end
        tx_n = tx_state_n == START ? 1'b0 : tx_state_n == DATA ? tx_sh_n[0] : tx_state_n == PARITY ? tx_par_n : 1'b1;
    end

    // TX state register; the serial line is registered and idles high
    always_ff @(posedge clk or negedge rstN)
        if (!rstN) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_pen   <= 1'b0;
            tx_par   <= 1'b0;
            tx_two   <= 1'b0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_sh    <= tx_sh_n;
            tx_pen   <= tx_pen_n;
            tx_par   <= tx_par_n;
            tx_two   <= tx_two_n;
            tx       <= tx_n;
        end

    logic                 rx_s1, rx_s2;
    state_t               rx_state, rx_state_n;
    logic [SW-1:0]        rx_cnt, rx_cnt_n;
    logic [BW-1:0]        rx_bit, rx_bit_n;
    logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
    logic                 rx_pen, rx_pen_n, rx_podd, rx_podd_n, rx_perr, rx_perr_n;
    logic                 rx_push, rx_mid, rx_ferr, rx_ovr;

    uart_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rstN(rstN), .wr(rx_push), .wr_data(rx_sh),
        .rd(rx_rd), .rd_data(rx_rd_data), .count(rx_count)
    );

    assign rx_empty = rx_count == '0;
    assign rx_valid = !rx_empty;
    assign rx_mid   = tick && rx_cnt == (rx_state == START ? HALF : LAST);
    assign rx_ferr  = rx_push && !rx_s2;
    assign rx_ovr   = rx_push && rx_count == CW'(FIFO_DEPTH) && !rx_rd;

    // RX next state; start is re-checked at half a bit to reject glitches
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = tick ? (rx_mid ? '0 : rx_cnt + 1'b1) : rx_cnt;
        rx_bit_n   = rx_bit;
        rx_sh_n    = rx_sh;
        rx_pen_n   = rx_pen;
        rx_podd_n  = rx_podd;
        rx_perr_n  = rx_perr;
        rx_push    = 1'b0;
        case (rx_state)
            IDLE:   if (!rx_s2) begin
                        rx_state_n = START;
                        rx_cnt_n   = '0;
                        rx_pen_n   = cfg_parity_en;
                        rx_podd_n  = cfg_parity_odd;
                        rx_perr_n  = 1'b0;
                    end
            START:  if (rx_mid) begin
                        rx_state_n = rx_s2 ? IDLE : DATA;
                        rx_bit_n   = '0;
                    end
            DATA:   if (rx_mid) begin
                        rx_sh_n  = {rx_s2, rx_sh[DATA_BITS-1:1]};
                        rx_bit_n = rx_bit + 1'b1;
                        if (rx_bit == LAST_BIT) rx_state_n = rx_pen ? PARITY : STOP;
                    end
            PARITY: if (rx_mid) begin
                        rx_state_n = STOP;
                        rx_perr_n  = rx_s2 != (^rx_sh ^ rx_podd);
                    end
            STOP:   if (rx_mid) begin
                        rx_state_n = IDLE;
                        rx_push    = 1'b1;
                    end
            default: ;
        endcase
    end

    // RX synchroniser and state register
    always_ff @(posedge clk or negedge rstN)
        if (!rstN) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_pen   <= 1'b0;
            rx_podd  <= 1'b0;
            rx_perr  <= 1'b0;
        end else begin
            rx_s1    <= rx;
            rx_s2    <= rx_s1;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_sh    <= rx_sh_n;
            rx_pen   <= rx_pen_n;
            rx_podd  <= rx_podd_n;
            rx_perr  <= rx_perr_n;
        end

    // sticky error flags; a new event beats a simultaneous clear
    always_ff @(posedge clk or negedge rstN)
        if (!rstN) err <= '0;
        else err <= (err_clr ? 3'b000 : err) | {rx_ovr, rx_push && rx_perr, rx_ferr};
endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: directed self-checking bench for uart_ctrl
module tb_uart_ctrl;
    logic       clk = 1'b0, rstN = 1'b0;
    logic [15:0] cfg_div = '0;
    logic       cfg_parity_en = 1'b0, cfg_parity_odd = 1'b0, cfg_two_stop = 1'b0;
    logic       rx, tx, rx_drv = 1'b1, loop = 1'b0;
    logic       rx_rd = 1'b0, rx_valid, rx_empty, tx_wr = 1'b0, tx_full, tx_busy, err_clr = 1'b0;
    logic [7:0] rx_rd_data, tx_wr_data = '0;
    logic [2:0] rx_count, err;
    int         vectors = 0, miscompares = 0;

    assign rx = loop ? tx : rx_drv;
    always #5 clk = ~clk;

    uart_ctrl #(.DATA_BITS(8), .FIFO_DEPTH(4), .DIV_WIDTH(16), .OVERSAMPLE(16)) dut (
        .clk(clk), .rstN(rstN), .cfg_div(cfg_div), .cfg_parity_en(cfg_parity_en),
        .cfg_parity_odd(cfg_parity_odd), .cfg_two_stop(cfg_two_stop), .rx(rx), .tx(tx),
        .rx_rd(rx_rd), .rx_rd_data(rx_rd_data), .rx_valid(rx_valid), .rx_empty(rx_empty),
        .rx_count(rx_count), .tx_wr(tx_wr), .tx_wr_data(tx_wr_data), .tx_full(tx_full),
        .tx_busy(tx_busy), .err(err), .err_clr(err_clr)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pop;
        rx_rd = 1'b1; cyc(1); rx_rd = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit, input logic stop, input int stop_len);
        rx_drv = 1'b0; cyc(16);
        for (int i = 0; i < 8; i++) begin rx_drv = d[i]; cyc(16); end
        if (pen) begin rx_drv = pbit; cyc(16); end
        rx_drv = stop; cyc(stop_len);
        rx_drv = 1'b1; cyc(24);
    endtask

    task automatic test_reset;
        rstN = 1'b0; cyc(3);
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b want 1", tx); end
        vectors++; if (rx_empty !== 1'b1) begin miscompares++; $display("FAIL reset_rx_empty: got %b want 1", rx_empty); end
        vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        vectors++; if (rx_count !== 3'd0) begin miscompares++; $display("FAIL reset_rx_count: got %0d want 0", rx_count); end
        vectors++; if (tx_full !== 1'b0) begin miscompares++; $display("FAIL reset_tx_full: got %b want 0", tx_full); end
        vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
        vectors++; if (err !== 3'b000) begin miscompares++; $display("FAIL reset_err: got %b want 000", err); end
        vectors++; if (rx_rd_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_rd_data: got %h want 00", rx_rd_data); end
        rstN = 1'b1; cyc(2);
    endtask

    task automatic test_loopback;
        int n;
        cfg_div = 16'd0; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_two_stop = 1'b0; loop = 1'b1;
        cyc(4);
        tx_wr = 1'b1; tx_wr_data = 8'hA5; cyc(1); tx_wr = 1'b0;
        vectors++; if (tx_busy !== 1'b1) begin miscompares++; $display("FAIL lb_busy_n1: got %b want 1", tx_busy); end
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL lb_tx_n1: got %b want 1", tx); end
        cyc(1);
        vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL lb_tx_n2: got %b want 0", tx); end
        n = 0;
        while (tx_busy === 1'b1 && n < 400) begin cyc(1); n++; end
        vectors++; if (n != 160) begin miscompares++; $display("FAIL lb_frame_len: got %0d want 160", n); end
        n = 0;
        while (rx_valid !== 1'b1 && n < 200) begin cyc(1); n++; end
        vectors++; if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL lb_rx_valid: got %b want 1", rx_valid); end
        vectors++; if (rx_rd_data !== 8'hA5) begin miscompares++; $display("FAIL lb_rx_data: got %h want a5", rx_rd_data); end
        vectors++; if (err !== 3'b000) begin miscompares++; $display("FAIL lb_err: got %b want 000", err); end
        vectors++; if (rx_count !== 3'd1) begin miscompares++; $display("FAIL lb_rx_count: got %0d want 1", rx_count); end
        pop;
        vectors++; if (rx_empty !== 1'b1) begin miscompares++; $display("FAIL lb_rx_empty: got %b want 1", rx_empty); end
    endtask

    task automatic test_parity_burst;
        int j, n;
        logic [7:0] exp_w [3];
        exp_w[0] = 8'h00; exp_w[1] = 8'hFF; exp_w[2] = 8'h3C;
        cfg_div = 16'd3; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b1; cfg_two_stop = 1'b1; loop = 1'b1;
        cyc(10);
        tx_wr = 1'b1; tx_wr_data = 8'h00; cyc(1);
        tx_wr_data = 8'hFF; cyc(1);
        vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL pb_first_low: got %b want 0", tx); end
        tx_wr_data = 8'h3C;
        j = 0;
        while (tx_busy === 1'b1 && j < 3000) begin
            cyc(1); tx_wr = 1'b0; j++;
            if (j == 608 || j == 1376 || j == 2144) begin
                vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL pb_parity_bit@%0d: got %b want 1", j, tx); end
            end
            if (j == 800 || j == 1568) begin
                vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL pb_no_gap_start@%0d: got %b want 0", j, tx); end
            end
        end
        vectors++; if (j < 2301 || j > 2304) begin miscompares++; $display("FAIL pb_burst_len: got %0d want 2301..2304", j); end
        n = 0;
        while (rx_count !== 3'd3 && n < 400) begin cyc(1); n++; end
        vectors++; if (rx_count !== 3'd3) begin miscompares++; $display("FAIL pb_rx_count: got %0d want 3", rx_count); end
        vectors++; if (err !== 3'b000) begin miscompares++; $display("FAIL pb_err: got %b want 000", err); end
        for (int i = 0; i < 3; i++) begin
            vectors++; if (rx_rd_data !== exp_w[i]) begin miscompares++; $display("FAIL pb_rx_word%0d: got %h want %h", i, rx_rd_data, exp_w[i]); end
            pop;
        end
        cfg_div = 16'd0; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_two_stop = 1'b0; loop = 1'b0;
        cyc(10);
    endtask

    task automatic test_error_injection;
        loop = 1'b0; rx_drv = 1'b1; cfg_div = 16'd0; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0;
        cyc(4);
        send_frame(8'h12, 1'b1, 1'b1, 1'b1, 16);
        vectors++; if (err !== 3'b010) begin miscompares++; $display("FAIL ei_parity_err: got %b want 010", err); end
        vectors++; if (rx_count !== 3'd1) begin miscompares++; $display("FAIL ei_count1: got %0d want 1", rx_count); end
        vectors++; if (rx_rd_data !== 8'h12) begin miscompares++; $display("FAIL ei_data12: got %h want 12", rx_rd_data); end
        send_frame(8'h34, 1'b1, 1'b1, 1'b0, 12);
        vectors++; if (err !== 3'b011) begin miscompares++; $display("FAIL ei_frame_err: got %b want 011", err); end
        vectors++; if (rx_count !== 3'd2) begin miscompares++; $display("FAIL ei_count2: got %0d want 2", rx_count); end
        pop;
        vectors++; if (rx_rd_data !== 8'h34) begin miscompares++; $display("FAIL ei_data34: got %h want 34", rx_rd_data); end
        pop;
        err_clr = 1'b1; cyc(1); err_clr = 1'b0;
        vectors++; if (err !== 3'b000) begin miscompares++; $display("FAIL ei_err_clr: got %b want 000", err); end
        cfg_parity_en = 1'b0;
    endtask

    task automatic test_glitch;
        rx_drv = 1'b0; cyc(4); rx_drv = 1'b1; cyc(30);
        vectors++; if (rx_count !== 3'd0) begin miscompares++; $display("FAIL gl_no_push: got %0d want 0", rx_count); end
        vectors++; if (err !== 3'b000) begin miscompares++; $display("FAIL gl_err: got %b want 000", err); end
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 16);
        vectors++; if (rx_count !== 3'd1) begin miscompares++; $display("FAIL gl_count: got %0d want 1", rx_count); end
        vectors++; if (rx_rd_data !== 8'h5A) begin miscompares++; $display("FAIL gl_data: got %h want 5a", rx_rd_data); end
        vectors++; if (err !== 3'b000) begin miscompares++; $display("FAIL gl_err_after: got %b want 000", err); end
        pop;
    endtask

    task automatic test_overrun;
        logic [7:0] w [5];
        w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44; w[4] = 8'h55;
        for (int i = 0; i < 5; i++) send_frame(w[i], 1'b0, 1'b0, 1'b1, 16);
        vectors++; if (rx_count !== 3'd4) begin miscompares++; $display("FAIL ov_count: got %0d want 4", rx_count); end
        vectors++; if (err !== 3'b100) begin miscompares++; $display("FAIL ov_err: got %b want 100", err); end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (rx_rd_data !== w[i]) begin miscompares++; $display("FAIL ov_word%0d: got %h want %h", i, rx_rd_data, w[i]); end
            pop;
        end
        vectors++; if (rx_empty !== 1'b1) begin miscompares++; $display("FAIL ov_empty: got %b want 1", rx_empty); end
    endtask

    task automatic test_reset_mid_frame;
        int n;
        loop = 1'b0; rx_drv = 1'b1; cfg_div = 16'd0;
        tx_wr = 1'b1; tx_wr_data = 8'h00; cyc(1);
        tx_wr_data = 8'h01; cyc(1);
        tx_wr_data = 8'h02; cyc(1);
        tx_wr_data = 8'h03; cyc(1);
        vectors++; if (tx_full !== 1'b0) begin miscompares++; $display("FAIL rm_not_full: got %b want 0", tx_full); end
        tx_wr_data = 8'h04; cyc(1); tx_wr = 1'b0;
        vectors++; if (tx_full !== 1'b1) begin miscompares++; $display("FAIL rm_full: got %b want 1", tx_full); end
        cyc(30);
        vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL rm_tx_data_bit: got %b want 0", tx); end
        rstN = 1'b0; #1;
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL rm_tx_async: got %b want 1", tx); end
        vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL rm_busy: got %b want 0", tx_busy); end
        vectors++; if (tx_full !== 1'b0) begin miscompares++; $display("FAIL rm_full_clr: got %b want 0", tx_full); end
        vectors++; if (rx_empty !== 1'b1) begin miscompares++; $display("FAIL rm_rx_empty: got %b want 1", rx_empty); end
        vectors++; if (err !== 3'b000) begin miscompares++; $display("FAIL rm_err: got %b want 000", err); end
        cyc(2); rstN = 1'b1; cyc(2);
        loop = 1'b1;
        tx_wr = 1'b1; tx_wr_data = 8'hC3; cyc(1); tx_wr = 1'b0;
        vectors++; if (tx_busy !== 1'b1) begin miscompares++; $display("FAIL rm_busy_after: got %b want 1", tx_busy); end
        cyc(1);
        vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL rm_tx_start: got %b want 0", tx); end
        n = 0;
        while (rx_valid !== 1'b1 && n < 300) begin cyc(1); n++; end
        vectors++; if (rx_rd_data !== 8'hC3 || rx_valid !== 1'b1) begin miscompares++; $display("FAIL rm_rx_data: got %h valid %b want c3 valid 1", rx_rd_data, rx_valid); end
        vectors++; if (err !== 3'b000) begin miscompares++; $display("FAIL rm_err_after: got %b want 000", err); end
        pop;
    endtask

    initial begin
        test_reset;
        test_loopback;
        test_parity_burst;
        test_error_injection;
        test_glitch;
        test_overrun;
        test_reset_mid_frame;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
        $fatal(1);
    end
endmodule
